// File: rtl/if_pc_fetch_unit_if.sv
// Signal bundle between the fetch unit and its environment (hazard unit, PC_Adder,
// instruction memory, decode stage). The fetch unit is the master side.
interface if_pc_fetch_unit_if;
  // No valid/ready handshake: all inputs are sampled on every rising edge.
  // ifidValid qualifies the IF/ID fields (0 means a bubble is held there).
  logic        stall;
  logic        branchEn;
  logic [31:0] branchTarget;
  logic        jumpEn;
  logic [31:0] jumpTarget;
  logic [31:0] incrPC;
  logic [31:0] imemRdata;
  logic [31:0] fromPC;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
  logic        pcMisaligned;
  logic [31:0] fetchCount;

  modport master (
    input  stall, branchEn, branchTarget, jumpEn, jumpTarget, incrPC, imemRdata,
    output fromPC, ifidInstr, ifidPcPlus4, ifidValid, pcMisaligned, fetchCount
  );

  modport slave (
    output stall, branchEn, branchTarget, jumpEn, jumpTarget, incrPC, imemRdata,
    input  fromPC, ifidInstr, ifidPcPlus4, ifidValid, pcMisaligned, fetchCount
  );
endinterface

// File: rtl/if_pc_fetch_unit.sv
// MIPS instruction-fetch control: program counter, next-PC selection
// (jump > branch > stall > sequential) and the IF/ID pipeline register.
module if_pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst,
  if_pc_fetch_unit_if.master     bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] count_q, count_d;

  logic        redirect;
  logic [31:0] target;

  assign redirect = bus.jumpEn | bus.branchEn;
  assign target   = bus.jumpEn ? bus.jumpTarget : bus.branchTarget;

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_plus4_d   = pc_plus4_q;
    valid_d      = valid_q;
    misaligned_d = 1'b0;
    count_d      = count_q;
    if (redirect) begin
      // Redirect beats stall; the wrong-path word fetched this cycle is squashed.
      pc_d         = {target[31:2], 2'b00};
      misaligned_d = |target[1:0];
      instr_d      = NOP_INSTR;
      pc_plus4_d   = 32'h0;
      valid_d      = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = bus.incrPC;
      instr_d    = bus.imemRdata;
      pc_plus4_d = bus.incrPC;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_plus4_q   <= 32'h0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_plus4_q   <= pc_plus4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign bus.fromPC       = pc_q;
  assign bus.ifidInstr    = instr_q;
  assign bus.ifidPcPlus4  = pc_plus4_q;
  assign bus.ifidValid    = valid_q;
  assign bus.pcMisaligned = misaligned_q;
  assign bus.fetchCount   = count_q;

endmodule

// File: tb/tb_if_pc_fetch_unit.sv
// Self-checking bench for if_pc_fetch_unit: directed scenarios followed by
// randomized stall/branch/jump traffic against a behavioural fetch model.
module tb_if_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h00000000;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  if_pc_fetch_unit_if bus ();

  if_pc_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0)      return 32'h20080001;
    else if (addr == 32'h4) return 32'h20090002;
    else                    return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // PC_Adder and instruction memory, both combinational on fromPC.
  assign bus.incrPC    = bus.fromPC + 32'd4;
  assign bus.imemRdata = mem_word(bus.fromPC);

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_mis;
  logic [31:0] exp_q[$];   // words expected to reach IF/ID, in order

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP_INSTR;
    m_pp4   = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_cnt   = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    if (bus.jumpEn || bus.branchEn) begin
      tgt     = bus.jumpEn ? bus.jumpTarget : bus.branchTarget;
      m_mis   = (tgt % 4) != 0;
      m_pc    = tgt - (tgt % 4);
      m_instr = NOP_INSTR;
      m_pp4   = 32'h0;
      m_valid = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (!bus.stall) begin
        exp_q.push_back(mem_word(m_pc));
        m_instr = mem_word(m_pc);
        m_pp4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fromPC"},       bus.fromPC,              m_pc);
    check({tag, ".ifidInstr"},    bus.ifidInstr,           m_instr);
    check({tag, ".ifidPcPlus4"},  bus.ifidPcPlus4,         m_pp4);
    check({tag, ".ifidValid"},    {31'h0, bus.ifidValid},  {31'h0, m_valid});
    check({tag, ".pcMisaligned"}, {31'h0, bus.pcMisaligned}, {31'h0, m_mis});
    check({tag, ".fetchCount"},   bus.fetchCount,          m_cnt);
    if (m_valid && !m_mis && exp_q.size() > 0 && bus.ifidValid) begin
      check({tag, ".fetch_order"}, bus.ifidInstr, exp_q[$]);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
    bus.stall        = st;
    bus.branchEn     = br;
    bus.branchTarget = bt;
    bus.jumpEn       = jp;
    bus.jumpTarget   = jt;
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();

    // Reset and sequential fetch
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    cyc("seq0");
    check("seq0.instr_const", bus.ifidInstr, 32'h20080001);
    check("seq0.pc_const", bus.fromPC, 32'h4);
    cyc("seq1");
    check("seq1.instr_const", bus.ifidInstr, 32'h20090002);
    check("seq1.count_const", bus.fetchCount, 32'd2);

    // Stall three cycles at PC 8
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) cyc("stall");
    check("stall.pc_const", bus.fromPC, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("stall_release");
    check("stall_release.pc_const", bus.fromPC, 32'hC);
    cyc("to16");

    // Branch while stalled
    drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc("branch_stall");
    check("branch_stall.pc_const", bus.fromPC, 32'h40);

    // Jump beats branch
    drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h100);
    cyc("jump_vs_branch");
    check("jump_vs_branch.pc_const", bus.fromPC, 32'h100);

    // Misaligned jump target: pulse for one cycle
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
    cyc("misaligned");
    check("misaligned.pulse_const", {31'h0, bus.pcMisaligned}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("misaligned_clear");
    check("misaligned_clear.const", {31'h0, bus.pcMisaligned}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom(),
            $urandom_range(0, 9) == 0, $urandom());
      cyc("random");
    end

    // Reach PC 0x40 with a valid IF/ID, then async reset between edges
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3C);
    cyc("to3c");
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("to40");
    check("to40.valid_const", {31'h0, bus.ifidValid}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check_all("async_reset");
    check("async_reset.count_const", bus.fetchCount, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc("after_reset");
    check("after_reset.instr_const", bus.ifidInstr, 32'h20080001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
